// File: rtl/instruction_mem.sv
// Word-organised instruction memory for the IF stage of the 5-stage MIPS32 pipeline.
// Byte address in, registered 32-bit instruction out, one-cycle read latency.
// Preloaded with a small built-in boot image when INIT_FILE is empty.
// Optional write port enabled by defining IMEM_WRITE_EN; otherwise the block is a pure ROM.
module instruction_mem #(
  parameter int unsigned DEPTH     = 256,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        wen,
  input  logic [30:0] Address,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic          in_range;

  // Word index from the byte address. In range only when every index bit above AW is zero,
  // so large addresses never alias back onto low words.
  assign idx      = Address[AW+1:2];
  assign in_range = ~|Address[30:AW+2];

  // Byte-offset bits carry no information for a word-aligned fetch.
  logic unused_byte_offset;
  assign unused_byte_offset = ^Address[1:0];

  // Time-zero preload: clear everything, then apply the boot image.
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem[AW'(i)] = '0;
    end
    if (INIT_FILE == "") begin
      mem[AW'(0)] = 32'h2008_0005;
      mem[AW'(1)] = 32'h2009_000A;
      mem[AW'(2)] = 32'h0109_5020;
      mem[AW'(3)] = 32'hAC0A_0000;
      mem[AW'(4)] = 32'h8C0B_0000;
      mem[AW'(5)] = 32'h0800_0005;
    end
  end

  // Registered read; reset wins, en=0 holds, out-of-range returns a NOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
    end else if (en) begin
      dout <= in_range ? mem[idx] : '0;
    end
  end

`ifdef IMEM_WRITE_EN
  // Synchronous write; non-blocking update makes a same-cycle read return the old word.
  always_ff @(posedge clk) begin
    if (!reset && en && wen && in_range) begin
      mem[idx] <= din;
    end
  end
`else
  // ROM build: write controls are accepted but have no effect.
  logic unused_write_port;
  assign unused_write_port = wen ^ (^din);
`endif

endmodule

// File: tb/tb_instruction_mem.sv
// Self-checking bench for instruction_mem: directed vector table plus latency sequences.
// Covers both the ROM build and the IMEM_WRITE_EN build.
module tb_instruction_mem;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        wen;
  logic [30:0] Address;
  logic [31:0] din;
  logic [31:0] dout;

  always #5 clk = ~clk;

  instruction_mem #(.DEPTH(DEPTH), .INIT_FILE("")) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .wen     (wen),
    .Address (Address),
    .din     (din),
    .dout    (dout)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    logic        wen;
    logic [30:0] addr;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(string n, logic r, logic e, logic w,
                              logic [30:0] a, logic [31:0] d, logic [31:0] x);
    vec_t v;
    v.name = n; v.rst = r; v.en = e; v.wen = w; v.addr = a; v.din = d; v.exp = x;
    vecs.push_back(v);
  endfunction

  task automatic check(string n, logic [31:0] exp);
    total++;
    if (dout !== exp) begin
      bad++;
      $display("FAIL %s: dout=%h expected=%h", n, dout, exp);
    end
  endtask

  task automatic apply(vec_t v);
    @(negedge clk);
    reset   = v.rst;
    en      = v.en;
    wen     = v.wen;
    Address = v.addr;
    din     = v.din;
    @(posedge clk);
    #1;
    check(v.name, v.exp);
  endtask

  initial begin
    reset   = 1'b1;
    en      = 1'b1;
    wen     = 1'b0;
    Address = '0;
    din     = '0;

    // Reset holds dout at zero regardless of address
    add("rst0", 1, 1, 0, 31'h0,  32'h0, 32'h0);
    add("rst1", 1, 1, 0, 31'h4,  32'h0, 32'h0);
    add("rst2", 1, 1, 0, 31'h8,  32'h0, 32'h0);
    // Boot image walk
    add("boot0", 0, 1, 0, 31'h00, 32'h0, 32'h2008_0005);
    add("boot1", 0, 1, 0, 31'h04, 32'h0, 32'h2009_000A);
    add("boot2", 0, 1, 0, 31'h08, 32'h0, 32'h0109_5020);
    add("boot3", 0, 1, 0, 31'h0C, 32'h0, 32'hAC0A_0000);
    add("boot4", 0, 1, 0, 31'h10, 32'h0, 32'h8C0B_0000);
    add("boot5", 0, 1, 0, 31'h14, 32'h0, 32'h0800_0005);
    add("boot6", 0, 1, 0, 31'h18, 32'h0, 32'h0);
    // Enable low holds the last word
    add("en_rd8",  0, 1, 0, 31'h08, 32'h0, 32'h0109_5020);
    add("en_off0", 0, 0, 0, 31'h00, 32'h0, 32'h0109_5020);
    add("en_off1", 0, 0, 0, 31'h04, 32'h0, 32'h0109_5020);
    add("en_back", 0, 1, 0, 31'h00, 32'h0, 32'h2008_0005);
    // Byte offset ignored, range boundaries
    add("byteoff", 0, 1, 0, 31'h05,        32'h0, 32'h2009_000A);
    add("last_in", 0, 1, 0, 31'h3FC,       32'h0, 32'h0);
    add("rd1",     0, 1, 0, 31'h04,        32'h0, 32'h2009_000A);
    add("oor_400", 0, 1, 0, 31'h400,       32'h0, 32'h0);
    add("rd3",     0, 1, 0, 31'h0C,        32'h0, 32'hAC0A_0000);
    add("oor_max", 0, 1, 0, 31'h7FFF_FFFC, 32'h0, 32'h0);
    add("rd0_al",  0, 1, 0, 31'h401,       32'h0, 32'h0);
    // Mid-stream reset
    add("pre_rst", 0, 1, 0, 31'h10, 32'h0, 32'h8C0B_0000);
    add("mid_rst", 1, 1, 0, 31'h10, 32'h0, 32'h0);
    add("post_rst",0, 1, 0, 31'h10, 32'h0, 32'h8C0B_0000);
`ifdef IMEM_WRITE_EN
    add("wr_dead",  0, 1, 1, 31'h40,  32'hDEAD_BEEF, 32'h0);
    add("rd_dead",  0, 1, 0, 31'h40,  32'h0,         32'hDEAD_BEEF);
    add("wr_rf",    0, 1, 1, 31'h40,  32'h1234_5678, 32'hDEAD_BEEF);
    add("rd_new",   0, 1, 0, 31'h40,  32'h0,         32'h1234_5678);
    add("wr_oor",   0, 1, 1, 31'h440, 32'hFFFF_FFFF, 32'h0);
    add("rd_alias", 0, 1, 0, 31'h40,  32'h0,         32'h1234_5678);
    add("rd_oor",   0, 1, 0, 31'h440, 32'h0,         32'h0);
    add("wr_in_rst",1, 1, 1, 31'h40,  32'h0,         32'h0);
    add("rd_keep",  0, 1, 0, 31'h40,  32'h0,         32'h1234_5678);
    add("wr_en0",   0, 0, 1, 31'h40,  32'hAAAA_AAAA, 32'h1234_5678);
    add("rd_en0",   0, 1, 0, 31'h40,  32'h0,         32'h1234_5678);
    add("rd_boot0", 0, 1, 0, 31'h00,  32'h0,         32'h2008_0005);
`else
    add("rom_wr",   0, 1, 1, 31'h00, 32'hFFFF_FFFF, 32'h2008_0005);
    add("rom_rd",   0, 1, 0, 31'h00, 32'h0,         32'h2008_0005);
    add("rom_wr40", 0, 1, 1, 31'h40, 32'hFFFF_FFFF, 32'h0);
    add("rom_rst",  1, 1, 0, 31'h00, 32'h0,         32'h0);
    add("rom_rd40", 0, 1, 0, 31'h40, 32'h0,         32'h0);
    add("rom_rd0",  0, 1, 0, 31'h00, 32'h0,         32'h2008_0005);
`endif

    foreach (vecs[i]) begin
      apply(vecs[i]);
      total++;
      if ($isunknown(dout)) begin
        bad++;
        $display("FAIL %s_x: dout=%h expected=known", vecs[i].name, dout);
      end
    end

    // One-cycle latency: new address has no effect until the next edge
    apply('{"lat_seed", 1'b0, 1'b1, 1'b0, 31'h14, 32'h0, 32'h0800_0005});
    @(negedge clk);
    Address = 31'h08;
    #1;
    check("lat_before", 32'h0800_0005);
    @(posedge clk);
    #1;
    check("lat_after", 32'h0109_5020);

    // Enable dropped for several cycles while the address moves
    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      Address = 31'(k * 4);
      @(posedge clk);
      #1;
      check("hold_loop", 32'h0109_5020);
      @(negedge clk);
    end
    en = 1'b1;
    Address = 31'h04;
    @(posedge clk);
    #1;
    check("hold_release", 32'h2009_000A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
